// File: rtl/epb_slave_ctrl.sv
// epb_slave_ctrl: synchronous EPB slave for the ROACH CPLD.
// Synchronizes the asynchronous PowerPC EPB strobes and turns each bus
// access into a single-cycle read or write strobe on the register bus. It
// then returns read data and the ready handshake through the pad buffers.
module epb_slave_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  epb_cs_n,
  input  logic                  epb_r_w_n,
  input  logic [ADDR_WIDTH-1:0] epb_addr,
  input  logic [7:0]            epb_data_o,
  output logic [7:0]            epb_data_i,
  output logic                  epb_data_oe,
  output logic                  epb_rdy_i,
  output logic                  epb_rdy_oe,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wr_data,
  output logic                  bus_wr_strb,
  output logic                  bus_rd_strb,
  input  logic [7:0]            bus_rd_data,
  input  logic                  bus_ack,
  output logic                  timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RDY,
    ST_RELEASE
  } state_t;

  // Synchronizer and edge-detect flops.
  logic       cs_meta, cs_sync, cs_prev;
  logic       rw_meta, rw_sync;
  logic [1:0] flush_cnt;
  logic       armed;
  logic       start_q;

  // FSM and datapath state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_q, rd_d;
  logic             is_read_q, is_read_d;

  // Next values of the registered outputs.
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            wdata_d;
  logic                  wr_strb_d, rd_strb_d, tmo_d;
  logic                  rdy_oe_d, rdy_d, data_oe_d;
  logic [7:0]            data_i_d;

  // Synchronize cs_n / r_w_n and register the cs_n falling-edge start.
  // The start is only armed once the chain has held a genuine high sample,
  // so cs_n held low across reset cannot masquerade as a falling edge.
  always_ff @(posedge clk) begin
    // NOTE: every flop here resets synchronously, so reset is just another
    // input sampled at the clock edge.
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      rw_meta   <= 1'b1;
      rw_sync   <= 1'b1;
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the value its
      // neighbour held before the edge, which is what forms the chain.
      cs_meta <= epb_cs_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
      rw_meta <= epb_r_w_n;
      rw_sync <= rw_meta;
      if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
      if (flush_cnt == 2'd2 && cs_sync) armed <= 1'b1;
      start_q <= armed && !cs_sync && cs_prev;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and pad/bus output decode.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    is_read_d = is_read_q;
    addr_d    = bus_addr;
    wdata_d   = bus_wr_data;
    wr_strb_d = 1'b0;
    rd_strb_d = 1'b0;
    tmo_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          addr_d    = epb_addr;
          is_read_d = rw_sync;
          if (!rw_sync) wdata_d = epb_data_o;
          rd_strb_d = rw_sync;
          wr_strb_d = !rw_sync;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        // Ack wins over a simultaneous timeout.
        if (bus_ack || cnt_q == CNT_LAST) begin
          if (is_read_q) rd_d = bus_ack ? bus_rd_data : 8'hFF;
          tmo_d   = !bus_ack;
          // A master that already dropped cs_n gets no ready pulse.
          state_d = cs_sync ? ST_RELEASE : ST_RDY;
        end
      end
      ST_RDY: begin
        if (cs_sync) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pad outputs follow the state being entered so they are registered
    // together with it. RELEASE drives rdy low for a cycle before tristate.
    rdy_oe_d  = (state_d == ST_RDY) || (state_d == ST_RELEASE);
    rdy_d     = (state_d == ST_RDY);
    data_oe_d = (state_d == ST_RDY) && is_read_d;
    data_i_d  = data_oe_d ? rd_d : 8'h00;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rd_q        <= 8'h00;
      is_read_q   <= 1'b0;
      bus_addr    <= '0;
      bus_wr_data <= 8'h00;
      bus_wr_strb <= 1'b0;
      bus_rd_strb <= 1'b0;
      timeout_err <= 1'b0;
      epb_rdy_oe  <= 1'b0;
      epb_rdy_i   <= 1'b0;
      epb_data_oe <= 1'b0;
      epb_data_i  <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      is_read_q   <= is_read_d;
      bus_addr    <= addr_d;
      bus_wr_data <= wdata_d;
      bus_wr_strb <= wr_strb_d;
      bus_rd_strb <= rd_strb_d;
      timeout_err <= tmo_d;
      epb_rdy_oe  <= rdy_oe_d;
      epb_rdy_i   <= rdy_d;
      epb_data_oe <= data_oe_d;
      epb_data_i  <= data_i_d;
    end
  end

endmodule
